dft_step_sched: RTL and testbench

Single-step debug sequencer that shares one clock domain between the DUT operation handshake and the scan-dump controller handshake.
- After `start`, it issues `num_steps` DUT operations.
- After every `dump_period` completed operations it runs one scan dump, and it always runs a final dump after the last operation.
- It sits above the DUT and scan controller in the DFT top level and replaces manual driving of both handshakes by the bench or host.

---
 rtl/dft_pkg.sv | 37 +++
 rtl/hs_req_fsm.sv | 76 +++++++
 rtl/dft_step_sched.sv | 209 ++++++++++++++++++++
 tb/tb_dft_step_sched.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared definitions for the single-step DFT debug sequencer.
// Contents:
//   - scan chain geometry (chain length, dump word width, words per dump)
//   - handshake direction constants for the valid/ack/commit protocol
//   - sequencer state encoding and requester phase encoding
package dft_pkg;

  // Scan chain geometry: one dump is the whole chain read out in words.
  localparam int CHAIN_LEN          = 64;
  localparam int DUMP_WORD_W        = 32;
  localparam int WORDS_PER_DUMP_DEF = CHAIN_LEN / DUMP_WORD_W;

  // Handshake directions as seen from the requester side:
  // val is driven by the requester, ack and commit come back from the target.
  localparam bit HS_VAL_IS_OUTPUT    = 1'b1;
  localparam bit HS_ACK_IS_OUTPUT    = 1'b0;
  localparam bit HS_COMMIT_IS_OUTPUT = 1'b0;

  // Top-level sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DUT_REQ  = 3'd1,
    ST_DUT_WAIT = 3'd2,
    ST_DFT_REQ  = 3'd3,
    ST_DFT_WAIT = 3'd4,
    ST_DFT_ACK  = 3'd5,
    ST_FIN      = 3'd6
  } sched_state_t;

  // Phases of one valid/ack/commit transaction.
  typedef enum logic [1:0] {
    HS_IDLE = 2'd0,
    HS_REQ  = 2'd1,
    HS_WAIT = 2'd2
  } hs_phase_t;

endpackage

// File: rtl/hs_req_fsm.sv
// Generic valid/ack/commit requester.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   launch          start a transaction (val rises next cycle); also re-arms
//                   in the cycle the current transaction completes
//   cancel          withdraw val while still waiting for ack
//   ack, commit     target responses; ack+commit in one cycle completes at once
//   val             registered request
//   accepted        ack sampled while requesting (combinational)
//   complete        transaction finished this cycle (combinational)
module hs_req_fsm
  import dft_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic launch,
  input  logic cancel,
  input  logic ack,
  input  logic commit,
  output logic val,
  output logic accepted,
  output logic complete
);

  hs_phase_t phase_r;
  hs_phase_t phase_nx;

  // Kept outside the next-phase block so these never depend on launch.
  assign accepted = (phase_r == HS_REQ) && ack;
  assign complete = ((phase_r == HS_REQ) && ack && commit) ||
                    ((phase_r == HS_WAIT) && commit);

  // Next-phase logic; an accepted request is never withdrawn by cancel.
  always_comb begin
    phase_nx = phase_r;
    case (phase_r)
      HS_IDLE: begin
        if (launch) phase_nx = HS_REQ;
        else        phase_nx = HS_IDLE;
      end
      HS_REQ: begin
        if (complete) begin
          if (launch) phase_nx = HS_REQ;
          else        phase_nx = HS_IDLE;
        end else if (ack) begin
          phase_nx = HS_WAIT;
        end else if (cancel) begin
          phase_nx = HS_IDLE;
        end else begin
          phase_nx = HS_REQ;
        end
      end
      HS_WAIT: begin
        if (complete) begin
          if (launch) phase_nx = HS_REQ;
          else        phase_nx = HS_IDLE;
        end else begin
          phase_nx = HS_WAIT;
        end
      end
      default: phase_nx = HS_IDLE;
    endcase
  end

  // Phase register and registered request output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_r <= HS_IDLE;
      val     <= 1'b0;
    end else begin
      phase_r <= phase_nx;
      val     <= (phase_nx == HS_REQ);
    end
  end

endmodule

// File: rtl/dft_step_sched.sv
// Single-step debug sequencer: runs num_steps DUT operations, takes a scan
// dump every dump_period operations and always one after the last operation.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   start, abort                      run control (start only seen in IDLE)
//   num_steps, dump_period            run configuration, latched on start
//   busy, done, err                   status (err sticky until next start)
//   steps_done, dumps_done            progress counters of the current run
//   dut_val_op/dut_op_ack/dut_op_commit           DUT operation handshake
//   dft_val_op/dft_op_ack/dft_op_commit           scan dump handshake
//   dft_out_strobe, dft_commit_ack    dump word strobe, commit acknowledge
module dft_step_sched
  import dft_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int WORDS_PER_DUMP = WORDS_PER_DUMP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [CNT_W-1:0] dump_period,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] steps_done,
  output logic [CNT_W-1:0] dumps_done,
  output logic             dut_val_op,
  input  logic             dut_op_ack,
  input  logic             dut_op_commit,
  output logic             dft_val_op,
  input  logic             dft_op_ack,
  input  logic             dft_op_commit,
  input  logic             dft_out_strobe,
  output logic             dft_commit_ack
);

  // Strobe counter saturates one above the expected count so both too few
  // and too many words are distinguishable.
  localparam int              SC_W   = $clog2(WORDS_PER_DUMP + 2);
  localparam logic [SC_W-1:0] SC_SAT = SC_W'(WORDS_PER_DUMP + 1);
  localparam logic [SC_W-1:0] SC_EXP = SC_W'(WORDS_PER_DUMP);

  sched_state_t     state_r;
  sched_state_t     state_nx;
  logic [CNT_W-1:0] num_steps_r;
  logic [CNT_W-1:0] dump_period_r;
  logic [CNT_W-1:0] period_cnt_r;
  logic             abort_pend_r;
  logic [SC_W-1:0]  strobe_cnt_r;

  logic [SC_W-1:0]  strobe_fin_s;
  logic [CNT_W-1:0] steps_inc_s;
  logic [CNT_W-1:0] period_inc_s;
  logic             period_hit_s;
  logic             dump_due_s;
  logic             abort_any_s;
  logic             dut_launch_s;
  logic             dft_launch_s;
  logic             dut_accepted_s;
  logic             dut_complete_s;
  logic             dft_accepted_s;
  logic             dft_complete_s;

  assign steps_inc_s  = steps_done + CNT_W'(1'b1);
  assign period_inc_s = period_cnt_r + CNT_W'(1'b1);
  assign period_hit_s = (dump_period_r != '0) && (period_inc_s == dump_period_r);
  assign dump_due_s   = (steps_inc_s == num_steps_r) || period_hit_s;
  assign abort_any_s  = abort || abort_pend_r;
  // Count including a strobe that arrives together with the commit.
  assign strobe_fin_s = (dft_out_strobe && (strobe_cnt_r != SC_SAT)) ?
                        (strobe_cnt_r + SC_W'(1'b1)) : strobe_cnt_r;

  hs_req_fsm u_dut_hs (
    .clk      (clk),
    .reset    (reset),
    .launch   (dut_launch_s),
    .cancel   (abort_any_s),
    .ack      (dut_op_ack),
    .commit   (dut_op_commit),
    .val      (dut_val_op),
    .accepted (dut_accepted_s),
    .complete (dut_complete_s)
  );

  hs_req_fsm u_dft_hs (
    .clk      (clk),
    .reset    (reset),
    .launch   (dft_launch_s),
    .cancel   (1'b0),
    .ack      (dft_op_ack),
    .commit   (dft_op_commit),
    .val      (dft_val_op),
    .accepted (dft_accepted_s),
    .complete (dft_complete_s)
  );

  // Sequencer next-state and requester launch decode.
  always_comb begin
    state_nx     = state_r;
    dut_launch_s = 1'b0;
    dft_launch_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (num_steps != '0) state_nx = ST_DUT_REQ;
          else                 state_nx = ST_DFT_REQ;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_DUT_REQ, ST_DUT_WAIT: begin
        if (dut_complete_s) begin
          if (dump_due_s || abort_any_s) state_nx = ST_DFT_REQ;
          else                           state_nx = ST_DUT_REQ;
        end else if (dut_accepted_s) begin
          state_nx = ST_DUT_WAIT;
        end else if ((state_r == ST_DUT_REQ) && abort_any_s) begin
          // Not yet accepted, so the request may be dropped.
          state_nx = ST_DFT_REQ;
        end else begin
          state_nx = state_r;
        end
      end
      ST_DFT_REQ, ST_DFT_WAIT: begin
        if (dft_complete_s)      state_nx = ST_DFT_ACK;
        else if (dft_accepted_s) state_nx = ST_DFT_WAIT;
        else                     state_nx = state_r;
      end
      ST_DFT_ACK: begin
        if ((steps_done == num_steps_r) || abort_any_s) state_nx = ST_FIN;
        else                                            state_nx = ST_DUT_REQ;
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase

    // A DUT_REQ -> DUT_REQ move after an immediate commit is a new operation.
    if ((state_nx == ST_DUT_REQ) && ((state_r != ST_DUT_REQ) || dut_complete_s)) begin
      dut_launch_s = 1'b1;
    end else begin
      dut_launch_s = 1'b0;
    end
    if ((state_nx == ST_DFT_REQ) && (state_r != ST_DFT_REQ)) begin
      dft_launch_s = 1'b1;
    end else begin
      dft_launch_s = 1'b0;
    end
  end

  // State register and state-decoded registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      dft_commit_ack <= 1'b0;
    end else begin
      state_r        <= state_nx;
      busy           <= (state_nx != ST_IDLE);
      done           <= (state_nx == ST_FIN);
      dft_commit_ack <= (state_nx == ST_DFT_ACK);
    end
  end

  // Run configuration, progress counters, abort and error bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_steps_r   <= '0;
      dump_period_r <= '0;
      period_cnt_r  <= '0;
      steps_done    <= '0;
      dumps_done    <= '0;
      abort_pend_r  <= 1'b0;
      err           <= 1'b0;
      strobe_cnt_r  <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      num_steps_r   <= num_steps;
      dump_period_r <= dump_period;
      period_cnt_r  <= '0;
      steps_done    <= '0;
      dumps_done    <= '0;
      abort_pend_r  <= 1'b0;
      err           <= 1'b0;
      strobe_cnt_r  <= '0;
    end else begin
      if (abort && (state_r != ST_IDLE) && (state_r != ST_FIN)) begin
        abort_pend_r <= 1'b1;
      end
      if (dut_complete_s) begin
        steps_done   <= steps_inc_s;
        period_cnt_r <= period_hit_s ? '0 : period_inc_s;
      end
      if (dft_complete_s) begin
        dumps_done <= dumps_done + CNT_W'(1'b1);
        if (strobe_fin_s != SC_EXP) begin
          err <= 1'b1;
        end
      end
      if (dft_launch_s) begin
        strobe_cnt_r <= '0;
      end else if ((state_r == ST_DFT_REQ) || (state_r == ST_DFT_WAIT)) begin
        strobe_cnt_r <= strobe_fin_s;
      end
    end
  end

endmodule

// File: tb/tb_dft_step_sched.sv
// Directed bench for dft_step_sched: behavioural DUT and scan responders,
// output monitors, and per-run checks against hand-computed expectations.
module tb_dft_step_sched;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_steps;
  logic [CNT_W-1:0] dump_period;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] steps_done;
  logic [CNT_W-1:0] dumps_done;
  logic             dut_val_op;
  logic             dut_op_ack;
  logic             dut_op_commit;
  logic             dft_val_op;
  logic             dft_op_ack;
  logic             dft_op_commit;
  logic             dft_out_strobe;
  logic             dft_commit_ack;

  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int ack_cyc = 0;
  int dut_val_cyc = 0;
  int overlap = 0;
  int n_dut_ops = 0;
  int n_dut_acks = 0;
  int n_dft_acks = 0;
  bit same_cyc = 1'b0;
  int dft_strobes = 2;

  always #5 clk = ~clk;

  dft_step_sched #(.CNT_W(CNT_W), .WORDS_PER_DUMP(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .num_steps      (num_steps),
    .dump_period    (dump_period),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .steps_done     (steps_done),
    .dumps_done     (dumps_done),
    .dut_val_op     (dut_val_op),
    .dut_op_ack     (dut_op_ack),
    .dut_op_commit  (dut_op_commit),
    .dft_val_op     (dft_val_op),
    .dft_op_ack     (dft_op_ack),
    .dft_op_commit  (dft_op_commit),
    .dft_out_strobe (dft_out_strobe),
    .dft_commit_ack (dft_commit_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // DUT responder: ack one cycle after the request, commit two cycles later,
  // or ack+commit in the request cycle when same_cyc is set.
  initial begin : dut_resp
    dut_op_ack = 1'b0;
    dut_op_commit = 1'b0;
    forever begin
      @(negedge clk);
      dut_op_ack = 1'b0;
      dut_op_commit = 1'b0;
      if (dut_val_op) begin
        if (same_cyc) begin
          dut_op_ack = 1'b1;
          dut_op_commit = 1'b1;
          n_dut_acks++;
          n_dut_ops++;
        end else begin
          @(negedge clk);
          dut_op_ack = 1'b1;
          n_dut_acks++;
          @(negedge clk);
          dut_op_ack = 1'b0;
          @(negedge clk);
          dut_op_commit = 1'b1;
          n_dut_ops++;
        end
      end
    end
  end

  // Scan responder: ack at once, dft_strobes words, then commit; in same_cyc
  // mode one word while requesting, then word+ack+commit together.
  initial begin : dft_resp
    dft_op_ack = 1'b0;
    dft_op_commit = 1'b0;
    dft_out_strobe = 1'b0;
    forever begin
      @(negedge clk);
      dft_op_ack = 1'b0;
      dft_op_commit = 1'b0;
      dft_out_strobe = 1'b0;
      if (dft_val_op) begin
        if (same_cyc) begin
          dft_out_strobe = 1'b1;
          @(negedge clk);
          dft_out_strobe = 1'b1;
          dft_op_ack = 1'b1;
          dft_op_commit = 1'b1;
          n_dft_acks++;
        end else begin
          dft_op_ack = 1'b1;
          n_dft_acks++;
          @(negedge clk);
          dft_op_ack = 1'b0;
          for (int i = 0; i < dft_strobes; i++) begin
            dft_out_strobe = 1'b1;
            @(negedge clk);
            dft_out_strobe = 1'b0;
          end
          dft_op_commit = 1'b1;
        end
      end
    end
  end

  // Output monitor sampled on the falling edge.
  initial begin : mon
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (dft_commit_ack) ack_cyc++;
      if (dut_val_op) dut_val_cyc++;
      if (dut_val_op && dft_val_op) overlap++;
    end
  end

  task automatic run(input string name, input int ns, input int dp, input bit sc,
                     input int strb, input bit poke, input int abort_at,
                     input int e_steps, input int e_dumps, input bit e_err);
    same_cyc = sc;
    dft_strobes = strb;
    done_cnt = 0; ack_cyc = 0; dut_val_cyc = 0; overlap = 0;
    n_dut_ops = 0; n_dut_acks = 0; n_dft_acks = 0;
    @(negedge clk);
    num_steps = CNT_W'(ns);
    dump_period = CNT_W'(dp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".err_clr"}, 32'(err), 32'd0);
    chk({name, ".busy"}, 32'(busy), 32'd1);
    if (poke) begin
      repeat (3) @(negedge clk);
      num_steps = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_at > 0) begin
      for (int c = 0; c < 200 && n_dut_acks < abort_at; c++) @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    for (int c = 0; c < 400 && done_cnt == 0; c++) @(negedge clk);
    @(negedge clk);
    chk({name, ".steps"}, 32'(steps_done), 32'(e_steps));
    chk({name, ".dumps"}, 32'(dumps_done), 32'(e_dumps));
    chk({name, ".err"}, 32'(err), 32'(e_err));
    chk({name, ".done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, ".ack_cycles"}, 32'(ack_cyc), 32'(e_dumps));
    chk({name, ".dut_ops"}, 32'(n_dut_ops), 32'(e_steps));
    chk({name, ".val_overlap"}, 32'(overlap), 32'd0);
    chk({name, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : main
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_steps = '0;
    dump_period = '0;
    repeat (3) @(negedge clk);
    chk("rst.flags", 32'({busy, done, err, dut_val_op, dft_val_op, dft_commit_ack}), 32'd0);
    chk("rst.steps", 32'(steps_done), 32'd0);
    chk("rst.dumps", 32'(dumps_done), 32'd0);
    reset = 1'b0;

    //   name        ns dp sc strb poke abort steps dumps err
    run("basic",     3, 0, 0, 2,   0,   0,    3,    1,    0);
    run("period",    4, 2, 0, 2,   1,   0,    4,    2,    0);
    run("zero",      0, 5, 0, 2,   0,   0,    0,    1,    0);
    chk("zero.val_cyc", 32'(dut_val_cyc), 32'd0);
    run("same",      2, 1, 1, 2,   0,   0,    2,    2,    0);
    chk("same.val_cyc", 32'(dut_val_cyc), 32'd2);
    run("strb1",     1, 0, 0, 1,   0,   0,    1,    1,    1);
    run("strb3",     1, 0, 0, 3,   0,   0,    1,    1,    1);
    run("strb2",     1, 0, 0, 2,   0,   0,    1,    1,    0);
    run("abort",     5, 0, 0, 2,   0,   2,    2,    1,    0);

    // Reset while the dump is in DFT_WAIT.
    same_cyc = 1'b0;
    dft_strobes = 2;
    n_dft_acks = 0;
    @(negedge clk);
    num_steps = 16'd1;
    dump_period = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && n_dft_acks == 0; c++) @(negedge clk);
    @(negedge clk);
    #2;
    chk("rst_mid.busy_pre", 32'(busy), 32'd1);
    chk("rst_mid.steps_pre", 32'(steps_done), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid.flags", 32'({busy, done, err, dut_val_op, dft_val_op, dft_commit_ack}), 32'd0);
    chk("rst_mid.steps", 32'(steps_done), 32'd0);
    chk("rst_mid.dumps", 32'(dumps_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid.idle", 32'(busy), 32'd0);
    run("post_rst",  2, 0, 0, 2,   0,   0,    2,    1,    0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
